keypad_entry_nd: RTL
====================

Name: keypad_entry_nd

Overview:
- Parametrised successor to the two-digit keypad front end: scans a 4x4 matrix keypad, debounces with a press/release state machine, and keeps the last NUM_DIGITS key values in a shift register.
- Time-multiplexes those digits onto one shared seven-segment decoder.
- Sits between the keypad pins and the existing hex-to-segment decoder; all logic runs on one system clock.

Parameters:
- NUM_DIGITS, 2, number of stored and displayed digits (1..8).
- SCAN_DIV, 1000, clk cycles each column is driven while scanning (>=4).
- DEBOUNCE_CYCLES, 40000, consecutive stable clk cycles required to accept a press or a release (>=2).
- REFRESH_DIV, 192000, clk cycles each display digit is enabled (>=1).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- keypad_hori  input  4  row lines, active-low (pulled up), asynchronous.
- clear  input  1  synchronous; zeroes all stored digits.
- keypad_vert  output  4  column drive, one-hot active-low.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_code  output  4  hex value of the last accepted key.
- digits  output  4*NUM_DIGITS  stored digits; [3:0] is newest.
- display_digit  output  4  hex value of the currently enabled digit.
- digit_en  output  NUM_DIGITS  one-hot active-high digit enable.

Behaviour:
- Reset values:
  - keypad_vert=4'b1110 (column 0 driven).
  - key_valid=0, key_code=0, digits=0.
  - Display index 0, so digit_en=1 and display_digit=0.
  - FSM in SCAN; all counters 0.
- Synchroniser: keypad_hori passes through a 2-flop synchroniser (reset to 4'b1111). All row tests use the synchronised value.
- Key map, row r / column c:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: E 0 F D
- FSM SCAN:
  - The column advances c -> c+1 mod 4 every SCAN_DIV cycles.
  - Rows are sampled on the last cycle of each column period.
  - If any row is low, latch c and the lowest-index low row, then go to DEBOUNCE_PRESS. keypad_vert freezes on c.
- FSM DEBOUNCE_PRESS:
  - The counter increments while the latched row stays low.
  - If the latched row goes high before DEBOUNCE_CYCLES, return to SCAN. Scanning resumes at c+1 and no event is produced.
  - On reaching DEBOUNCE_CYCLES: key_valid pulses for 1 cycle, key_code updates, digits shift (digit k <= digit k-1, digit 0 <= new code). Then go to HELD.
- FSM HELD:
  - The column stays frozen.
  - Other keys are ignored, including a second key in the same column.
  - When the latched row goes high, go to DEBOUNCE_RELEASE.
- FSM DEBOUNCE_RELEASE:
  - The counter increments while the latched row stays high.
  - If the row goes low again, return to HELD; the counter clears and no new event is produced.
  - On reaching DEBOUNCE_CYCLES, go to SCAN at column c+1.
- Latency: press accepted exactly DEBOUNCE_CYCLES cycles after entering DEBOUNCE_PRESS. key_valid is registered.
- clear:
  - Zeroes digits in the following cycle. key_code, the FSM and the display are unaffected.
  - If clear coincides with key_valid, clear wins and digits=0.
- Display:
  - A refresh counter advances the index every REFRESH_DIV cycles, wrapping NUM_DIGITS-1 -> 0.
  - digit_en = 1<<index. display_digit = digits[4*index +: 4]; it reflects a shift in the same cycle that digits changes.
  - With NUM_DIGITS=1, digit_en is constantly 1.
- Reset mid-operation: asynchronous return to reset values from any state; a partially debounced key is discarded.

Decomposition:
- Package keypad_pkg:
  - FSM state enum (SCAN, DEBOUNCE_PRESS, HELD, DEBOUNCE_RELEASE).
  - Row/column count constants (4).
  - Function keymap(row, col) returning the 4-bit code.
- Sub-module keypad_debounce_fsm: scan counter, column drive, FSM and debounce counter. Outputs key_valid and key_code.
- The top holds the synchroniser, the digit shift register and the display multiplexer.

Test Plan:
All scenarios use NUM_DIGITS=3, SCAN_DIV=4, DEBOUNCE_CYCLES=8, REFRESH_DIV=3.
- Reset, no keys -> keypad_vert cycles 1110,1101,1011,0111 every 4 cycles; key_valid never asserts; digit_en cycles 001,010,100 every 3 cycles.
- Hold row 1 low only while column 2 is driven, for 20 cycles, then release -> one key_valid pulse, key_code=6, digits=12'h006; no second pulse after release.
- Press sequence 1, A, 0, D with clean presses -> digits=12'hA0D (newest D at [3:0]); key 1 has shifted out.
- Press glitch lasting 5 cycles -> no key_valid; scan resumes at the next column.
- Key held, row bounces high for 3 cycles then low -> single key_valid; FSM stays in HELD.
- Assert clear together with a key_valid pulse -> digits=0, key_code updated. Assert reset mid-debounce -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad entry front end:
// FSM state encoding, matrix dimensions and the row/column to hex key map.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } kp_state_e;

  // Physical layout: rows 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
  function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Column scanner plus press/release debounce FSM. Freezes the column while a
// key is being qualified or held and emits a one-cycle key_valid with its code.
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 40000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_i,
  output logic [3:0] keypad_vert_o,
  output logic       key_valid_o,
  output logic [3:0] key_code_o
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  kp_state_e         state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;

  logic              row_low_s;
  logic              any_low_s;
  logic [1:0]        low_row_s;

  assign row_low_s = ~rows_i[row_q];
  assign any_low_s = ~(&rows_i);

  always_comb begin
    low_row_s = 2'd3;
    if (!rows_i[0])      low_row_s = 2'd0;
    else if (!rows_i[1]) low_row_s = 2'd1;
    else if (!rows_i[2]) low_row_s = 2'd2;
    else                 low_row_s = 2'd3;
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (any_low_s) begin
            state_d   = DEBOUNCE_PRESS;
            row_d     = low_row_s;
            deb_cnt_d = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      DEBOUNCE_PRESS: begin
        if (row_low_s) begin
          if (deb_cnt_q == DEB_LAST) begin
            key_valid_d = 1'b1;
            key_code_d  = keymap(row_q, col_q);
            state_d     = HELD;
            deb_cnt_d   = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end else begin
          // Glitch: drop it and carry on scanning from the next column.
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end
      end
      HELD: begin
        if (!row_low_s) begin
          state_d   = DEBOUNCE_RELEASE;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = '0;
        end
      end
      DEBOUNCE_RELEASE: begin
        if (!row_low_s) begin
          if (deb_cnt_q == DEB_LAST) begin
            state_d    = SCAN;
            col_d      = col_q + 2'd1;
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end else begin
          state_d   = HELD;
          deb_cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign keypad_vert_o = ~(4'b0001 << col_q);
  assign key_valid_o   = key_valid_q;
  assign key_code_o    = key_code_q;

endmodule

// File: rtl/keypad_entry_nd.sv
// Keypad entry top: row synchroniser, NUM_DIGITS-deep digit shift register and
// the time-multiplexed display selector feeding a shared seven-segment decoder.
module keypad_entry_nd
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 2,
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int REFRESH_DIV     = 192000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              keypad_hori,
  input  logic                    clear,
  output logic [3:0]              keypad_vert,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              display_digit,
  output logic [NUM_DIGITS-1:0]   digit_en
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic [3:0]              sync1_q, sync2_q;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  keypad_debounce_fsm #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_fsm (
    .clk           (clk),
    .reset         (reset),
    .rows_i        (sync2_q),
    .keypad_vert_o (keypad_vert),
    .key_valid_o   (key_valid),
    .key_code_o    (key_code)
  );

  // clear has priority over an arriving key so a coincident press is dropped.
  always_comb begin
    digits_d = digits_q;
    if (clear) begin
      digits_d = '0;
    end else if (key_valid) begin
      digits_d[3:0] = key_code;
      for (int k = 1; k < NUM_DIGITS; k++) begin
        digits_d[4*k +: 4] = digits_q[4*(k-1) +: 4];
      end
    end else begin
      digits_d = digits_q;
    end
  end

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    idx_d     = idx_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      ref_cnt_d = ref_cnt_q + REF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      digits_q  <= '0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      sync1_q   <= keypad_hori;
      sync2_q   <= sync1_q;
      digits_q  <= digits_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign digits        = digits_q;
  assign digit_en      = NUM_DIGITS'(1'b1) << idx_q;
  assign display_digit = digits_q[{idx_q, 2'b00} +: 4];

endmodule
